frame_ram_arbiter: RTL

Controller that owns the ports of the 640×480 one-bit-per-pixel frame RAM (one 480-bit column word per address, 640 addresses, one-cycle registered read). It shares the single read port between the VGA column fetcher and the game's trail painter, performs read-modify-write pixel updates with collision reporting, and runs a full-screen clear at round start. It sits between the game logic / VGA path and the frame RAM.

---
 rtl/frame_ram_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/frame_ram_arbiter.sv
// Frame RAM port owner: display fetch (2-cycle latency, absolute read priority), pixel RMW (ack at +3, +1 off-screen), full clear.
// Backpressure: pix_req stalls while display reads or a clear is running; display is never stalled.
module frame_ram_arbiter #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              disp_req,
   input  logic [9:0]        disp_x,
   output logic [HEIGHT-1:0] disp_data,
   output logic              disp_valid,
   input  logic              pix_req,
   input  logic [9:0]        pix_x,
   input  logic [8:0]        pix_y,
   input  logic              pix_val,
   output logic              pix_ack,
   output logic              pix_hit,
   input  logic              clr_start,
   output logic              clr_busy,
   output logic              ram_we,
   output logic [19:0]       ram_write_address,
   output logic [19:0]       ram_read_address,
   output logic [HEIGHT-1:0] ram_data_In,
   input  logic [HEIGHT-1:0] ram_data_Out
);

   localparam logic [9:0] WIDTH_L  = 10'(WIDTH);
   localparam logic [8:0] HEIGHT_L = 9'(HEIGHT);
   localparam logic [9:0] LAST_COL = 10'(WIDTH - 1);

   typedef enum logic [2:0] {S_IDLE, S_WAIT1, S_WAIT2, S_WRITE, S_CLEAR} state_t;

   state_t            state_q, state_d;
   logic [9:0]        rd_addr_q, rd_addr_d;
   logic [9:0]        wr_addr_q, wr_addr_d;
   logic [HEIGHT-1:0] wdata_q, wdata_d;
   logic              we_q, we_d;
   logic              ack_q, ack_d;
   logic              hit_q, hit_d;
   logic              busy_q, busy_d;
   logic [9:0]        cnt_q, cnt_d;
   logic [9:0]        x_q, x_d;
   logic [8:0]        y_q, y_d;
   logic              val_q, val_d;
   logic              dv1_q, dv1_d;
   logic              dv2_q, dv2_d;
   logic              pix_wall;

   assign pix_wall = (pix_x >= WIDTH_L) || (pix_y >= HEIGHT_L);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= S_IDLE;
         rd_addr_q <= '0;
         wr_addr_q <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         ack_q     <= 1'b0;
         hit_q     <= 1'b0;
         busy_q    <= 1'b0;
         cnt_q     <= '0;
         x_q       <= '0;
         y_q       <= '0;
         val_q     <= 1'b0;
         dv1_q     <= 1'b0;
         dv2_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         wdata_q   <= wdata_d;
         we_q      <= we_d;
         ack_q     <= ack_d;
         hit_q     <= hit_d;
         busy_q    <= busy_d;
         cnt_q     <= cnt_d;
         x_q       <= x_d;
         y_q       <= y_d;
         val_q     <= val_d;
         dv1_q     <= dv1_d;
         dv2_q     <= dv2_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (clr_start)                 state_d = S_CLEAR;
            else if (pix_req && pix_wall)  state_d = S_WRITE;
            else if (pix_req && !disp_req) state_d = S_WAIT1;
         end
         S_WAIT1: state_d = S_WAIT2;
         S_WAIT2: state_d = S_WRITE;
         S_WRITE: state_d = S_IDLE;
         S_CLEAR: if (cnt_q == LAST_COL) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Registered RAM-side outputs; the display path always wins the read address.
   always_comb begin
      rd_addr_d = disp_req ? disp_x : rd_addr_q;
      wr_addr_d = wr_addr_q;
      wdata_d   = wdata_q;
      we_d      = 1'b0;
      ack_d     = 1'b0;
      hit_d     = hit_q;
      busy_d    = 1'b0;
      cnt_d     = cnt_q;
      x_d       = x_q;
      y_d       = y_q;
      val_d     = val_q;
      dv1_d     = disp_req;
      dv2_d     = dv1_q;
      case (state_q)
         S_IDLE: begin
            if (clr_start) begin
               we_d      = 1'b1;
               wr_addr_d = '0;
               wdata_d   = '0;
               busy_d    = 1'b1;
               cnt_d     = '0;
            end else if (pix_req && pix_wall) begin
               ack_d = 1'b1;
               hit_d = 1'b1;
            end else if (pix_req && !disp_req) begin
               x_d       = pix_x;
               y_d       = pix_y;
               val_d     = pix_val;
               rd_addr_d = pix_x;
            end
         end
         S_WAIT2: begin
            wdata_d      = ram_data_Out;
            wdata_d[y_q] = val_q;
            wr_addr_d    = x_q;
            we_d         = 1'b1;
            hit_d        = ram_data_Out[y_q];
            ack_d        = 1'b1;
         end
         S_CLEAR: begin
            if (cnt_q != LAST_COL) begin
               we_d      = 1'b1;
               busy_d    = 1'b1;
               wdata_d   = '0;
               wr_addr_d = cnt_q + 10'd1;
               cnt_d     = cnt_q + 10'd1;
            end else begin
               cnt_d = '0;
            end
         end
         default: ;
      endcase
   end

   assign disp_data         = ram_data_Out;
   assign disp_valid        = dv2_q;
   assign pix_ack           = ack_q;
   assign pix_hit           = hit_q;
   assign clr_busy          = busy_q;
   assign ram_we            = we_q;
   assign ram_write_address = {10'd0, wr_addr_q};
   assign ram_read_address  = {10'd0, rd_addr_q};
   assign ram_data_In       = wdata_q;

endmodule
